// File: rtl/dial_lock_ctrl_if.sv
// Signal bundle between a rotary-dial front panel and its lock controller.
// master = panel side (code, dial, tryopen); slave = controller.
interface dial_lock_ctrl_if #(
    parameter int N_POS    = 10,
    parameter int N_DIGITS = 6,
    parameter int DW       = 4,
    parameter int MAX_FAIL = 3
);
    logic [N_DIGITS*DW-1:0]          code;
    logic [N_POS-1:0]                dial;
    logic                            tryopen;
    logic                            open;
    logic                            locked_out;
    logic                            entry_err;
    logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt;
    logic [$clog2(N_DIGITS+1)-1:0]   digits_cnt;

    modport master (
        output code, dial, tryopen,
        input  open, locked_out, entry_err,
        input  fail_cnt, digits_cnt
    );

    modport slave (
        input  code, dial, tryopen,
        output open, locked_out, entry_err,
        output fail_cnt, digits_cnt
    );
endinterface

// File: rtl/dial_lock_ctrl.sv
// Rotary-dial combination lock: records a digit at each direction
// reversal, checks the entry on tryopen, counts failures, locks out.
module dial_lock_ctrl #(
    parameter int N_POS       = 10,
    parameter int N_DIGITS    = 6,
    parameter int DW          = 4,
    parameter int MAX_FAIL    = 3,
    parameter int LOCKOUT_CYC = 1000
) (
    input  logic           clk,
    input  logic           rst_n,
    dial_lock_ctrl_if.slave bus
);
    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam int CW = $clog2(N_DIGITS + 1);
    localparam int LW = $clog2(LOCKOUT_CYC + 1);
    localparam int NB = N_DIGITS - 1;

    typedef enum logic [2:0] {
        IDLE,
        TRACK,
        ROTATE,
        OPEN,
        LOCKOUT
    } state_t;

    state_t              state, state_n;
    logic [N_POS-1:0]    dial_q;
    logic                try_q, try_p;
    logic [DW-1:0]       last, last_n;
    logic                dir, dir_n;
    logic [NB-1:0][DW-1:0] digs, digs_n;
    logic [CW-1:0]       cnt, cnt_n;
    logic                err, err_n;
    logic [FW-1:0]       fail, fail_n;
    logic [LW-1:0]       tmr, tmr_n;

    logic                valid, same;
    logic                up, dn, jump;
    logic                rise, hit;
    logic [DW-1:0]       pos, inc, dec;

    assign valid = $onehot(dial_q);
    assign rise  = try_q & ~try_p;

    always_comb begin
        pos = '0;
        for (int i = 0; i < N_POS; i++)
            if (dial_q[i]) pos = DW'(i);
    end

    assign inc = (last == DW'(N_POS - 1)) ? '0 : last + 1'b1;
    assign dec = (last == '0) ? DW'(N_POS - 1) : last - 1'b1;

    assign same = (pos == last);
    assign up   = valid && !same && (pos == inc);
    assign dn   = valid && !same && !up && (pos == dec);
    assign jump = valid && !same && !up && !dn;

    always_comb begin
        state_n = state;
        last_n  = last;
        dir_n   = dir;
        digs_n  = digs;
        cnt_n   = cnt;
        err_n   = err;
        fail_n  = fail;
        tmr_n   = tmr;
        hit     = 1'b0;
        unique case (state)
            IDLE: begin
                if (valid) begin
                    last_n  = pos;
                    state_n = TRACK;
                end
            end
            TRACK, ROTATE: begin
                if (valid && !same) last_n = pos;
                if (jump) begin
                    err_n = 1'b1;
                end else if (up || dn) begin
                    if (state == TRACK) begin
                        dir_n   = up;
                        state_n = ROTATE;
                    end else if (up != dir) begin
                        dir_n = up;
                        if (!err) begin
                            if (cnt == CW'(NB)) begin
                                err_n = 1'b1;
                            end else begin
                                for (int i = 0; i < NB; i++)
                                    if (CW'(i) == cnt) digs_n[i] = last;
                                cnt_n = cnt + 1'b1;
                            end
                        end
                    end
                end
                // The sample above is folded in before judging the entry.
                if (rise) begin
                    hit = !err_n && (cnt_n == CW'(NB)) &&
                          (last_n == bus.code[DW-1:0]);
                    for (int i = 0; i < NB; i++)
                        if (digs_n[i] !=
                            bus.code[(N_DIGITS-i)*DW-1 -: DW])
                            hit = 1'b0;
                    digs_n = '0;
                    cnt_n  = '0;
                    err_n  = 1'b0;
                    dir_n  = 1'b0;
                    if (hit) begin
                        fail_n  = '0;
                        state_n = OPEN;
                    end else begin
                        fail_n  = fail + 1'b1;
                        tmr_n   = '0;
                        state_n = (fail == FW'(MAX_FAIL - 1)) ?
                                  LOCKOUT : IDLE;
                    end
                end
            end
            OPEN: begin
                if (!try_q) state_n = IDLE;
            end
            LOCKOUT: begin
                if (tmr == LW'(LOCKOUT_CYC - 1)) begin
                    tmr_n   = '0;
                    fail_n  = '0;
                    state_n = IDLE;
                end else begin
                    tmr_n = tmr + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            dial_q <= '0;
            try_q  <= 1'b1;
            try_p  <= 1'b1;
            last   <= '0;
            dir    <= 1'b0;
            digs   <= '0;
            cnt    <= '0;
            err    <= 1'b0;
            fail   <= '0;
            tmr    <= '0;
        end else begin
            state  <= state_n;
            dial_q <= bus.dial;
            try_q  <= bus.tryopen;
            try_p  <= try_q;
            last   <= last_n;
            dir    <= dir_n;
            digs   <= digs_n;
            cnt    <= cnt_n;
            err    <= err_n;
            fail   <= fail_n;
            tmr    <= tmr_n;
        end
    end

    assign bus.open       = (state == OPEN);
    assign bus.locked_out = (state == LOCKOUT);
    assign bus.entry_err  = err;
    assign bus.fail_cnt   = fail;
    assign bus.digits_cnt = cnt;
endmodule

// File: tb/tb_dial_lock_ctrl.sv
// Bench for dial_lock_ctrl: directed scenarios plus random entries
// checked against a turning-point model of the lock.
module tb_dial_lock_ctrl;
    localparam int NP = 10;
    localparam int ND = 6;
    localparam int DW = 4;
    localparam int MF = 3;
    localparam int LC = 50;
    localparam int CD = ND * DW;
    localparam int FW = $clog2(MF + 1);
    localparam int CW = $clog2(ND + 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dial_lock_ctrl_if #(
        .N_POS(NP), .N_DIGITS(ND), .DW(DW), .MAX_FAIL(MF)
    ) bus ();

    dial_lock_ctrl #(
        .N_POS(NP), .N_DIGITS(ND), .DW(DW),
        .MAX_FAIL(MF), .LOCKOUT_CYC(LC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int cur_pos = 0;
    int fails_m = 0;
    int lock_hi = 0;
    int lock_start = 0;
    logic [NP-1:0] one = 1;
    logic [CD-1:0] code0 = 24'h172839;
    int seq[$] = '{7,8,9,0,1,0,9,8,7,8,9,0,1,2,1,0,9,8,9,
                   0,1,2,3,2,1,0,9};

    always @(posedge clk)
        if (bus.locked_out === 1'b1) lock_hi <= lock_hi + 1;

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_dial(input int p);
        bus.dial = one << p;
        cur_pos = p;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    function automatic void gen(input int start, input logic [CD-1:0] cd,
                                output int w[$]);
        int cur, dir, tg, st;
        w = {};
        cur = start;
        dir = 1;
        for (int k = 0; k < ND; k++) begin
            tg = int'(cd[(ND-k)*DW-1 -: DW]);
            st = (((tg - cur) * dir) % NP + NP) % NP;
            if (st == 0) st = NP;
            for (int j = 0; j < st; j++) begin
                cur = (cur + dir + NP) % NP;
                w.push_back(cur);
            end
            dir = -dir;
        end
    endfunction

    // Digits are the turning points of the walk; last element is final.
    function automatic void model(input int w[$], output int err,
                                  output int cnt,
                                  output logic [CD-1:0] cand);
        int d, s, sg;
        err = 0;
        cnt = 0;
        sg = 0;
        cand = '0;
        for (int i = 1; i < w.size(); i++) begin
            d = ((w[i] - w[i-1]) % NP + NP) % NP;
            s = (d == 1) ? 1 : ((d == NP - 1) ? -1 : 0);
            if (d != 0) begin
                if (s == 0) begin
                    err = 1;
                end else begin
                    if (sg != 0 && s != sg && err == 0) begin
                        if (cnt == ND - 1) err = 1;
                        else begin
                            cand = {cand[CD-DW-1:0], DW'(w[i-1])};
                            cnt++;
                        end
                    end
                    sg = s;
                end
            end
        end
        cand = {cand[CD-DW-1:0], DW'(w[w.size()-1])};
    endfunction

    task automatic reposition(input int p);
        bus.tryopen = 1'b0;
        rst_n = 1'b0;
        set_dial(p);
        hold(2);
        rst_n = 1'b1;
        hold(3);
        fails_m = 0;
    endtask

    task automatic wait_lockout(input string nm);
        int n;
        n = 0;
        while (bus.locked_out === 1'b1 && n < 10 * LC) begin
            hold(1);
            n++;
        end
        chk({nm, "_lock_end"}, int'(bus.locked_out), 0);
        chk({nm, "_lock_len"}, lock_hi - lock_start, LC);
        chk({nm, "_lock_fail"}, int'(bus.fail_cnt), 0);
        fails_m = 0;
    endtask

    task automatic attempt(input string nm, input int w[$], input int h,
                           input bit inv, input logic [CD-1:0] cd,
                           input bit same, input bit wl);
        int full[$];
        int e_err, e_cnt, e_fail, a, b, n;
        logic [CD-1:0] cand;
        bit hit, lk;
        full = w;
        full.push_front(cur_pos);
        model(full, e_err, e_cnt, cand);
        hit = (e_err == 0) && (e_cnt == ND - 1) && (cand == cd);
        e_fail = hit ? 0 : fails_m + 1;
        lk = !hit && (e_fail == MF);
        bus.code = CD'($urandom);
        n = w.size();
        for (int i = 0; i < n; i++) begin
            if (inv && $urandom_range(0, 2) == 0) begin
                a = $urandom_range(0, NP - 1);
                b = (a + $urandom_range(1, NP - 1)) % NP;
                if ($urandom_range(0, 1) == 1) bus.dial = '0;
                else bus.dial = (one << a) | (one << b);
                hold(1);
            end
            set_dial(w[i]);
            if (!(same && i == n - 1)) hold(h);
        end
        if (!(same && n > 0)) begin
            hold(1);
            chk({nm, "_digits"}, int'(bus.digits_cnt), e_cnt);
            chk({nm, "_err"}, int'(bus.entry_err), e_err);
        end
        lock_start = lock_hi;
        bus.code = cd;
        bus.tryopen = 1'b1;
        hold(1);
        chk({nm, "_open_early"}, int'(bus.open), 0);
        hold(1);
        chk({nm, "_open"}, int'(bus.open), int'(hit));
        chk({nm, "_fail"}, int'(bus.fail_cnt), e_fail);
        chk({nm, "_locked"}, int'(bus.locked_out), int'(lk));
        chk({nm, "_clr_cnt"}, int'(bus.digits_cnt), 0);
        chk({nm, "_clr_err"}, int'(bus.entry_err), 0);
        fails_m = e_fail;
        if (hit) begin
            hold(3);
            chk({nm, "_open_hold"}, int'(bus.open), 1);
            bus.tryopen = 1'b0;
            hold(1);
            chk({nm, "_open_late"}, int'(bus.open), 1);
            hold(1);
            chk({nm, "_close"}, int'(bus.open), 0);
        end else begin
            bus.tryopen = 1'b0;
            hold(2);
            if (lk && wl) wait_lockout(nm);
        end
    endtask

    task automatic test_reset;
        bus.tryopen = 1'b0;
        bus.code = code0;
        rst_n = 1'b0;
        set_dial(7);
        hold(3);
        chk("rst_open", int'(bus.open), 0);
        chk("rst_locked", int'(bus.locked_out), 0);
        chk("rst_err", int'(bus.entry_err), 0);
        chk("rst_fail", int'(bus.fail_cnt), 0);
        chk("rst_cnt", int'(bus.digits_cnt), 0);
        rst_n = 1'b1;
        hold(3);
    endtask

    task automatic test_open;
        attempt("open", seq, 10, 0, code0, 0, 1);
    endtask

    task automatic test_wrong;
        int w[$];
        reposition(7);
        w = seq;
        w.push_back(8);
        attempt("wrong", w, 10, 0, code0, 0, 1);
    endtask

    task automatic test_jump;
        int w[$] = '{7,8,9,0,1,0,9,8,7,8,9,0,1,2,1,0,9,8,9,
                     0,1,2,3,6,2,1,0,9};
        attempt("jump", w, 10, 0, code0, 0, 1);
    endtask

    task automatic test_wrap;
        reposition(9);
        set_dial(0);
        hold(3);
        bus.dial = '0;
        hold(2);
        bus.dial = 10'b0000101000;
        hold(2);
        chk("wrap_hold_cnt", int'(bus.digits_cnt), 0);
        chk("wrap_hold_err", int'(bus.entry_err), 0);
        set_dial(9);
        hold(3);
        chk("wrap_cnt", int'(bus.digits_cnt), 1);
        chk("wrap_err", int'(bus.entry_err), 0);
    endtask

    task automatic test_lockout;
        int none[$];
        none = {};
        reposition(7);
        attempt("lk1", none, 2, 0, code0, 0, 1);
        attempt("lk2", none, 2, 0, code0, 0, 1);
        attempt("lk3", none, 2, 0, code0, 0, 0);
        bus.code = code0;
        foreach (seq[i]) begin
            set_dial(seq[i]);
            hold(1);
        end
        bus.tryopen = 1'b1;
        hold(3);
        chk("lk_probe_open", int'(bus.open), 0);
        chk("lk_probe_lock", int'(bus.locked_out), 1);
        bus.tryopen = 1'b0;
        hold(1);
        wait_lockout("lk");
    endtask

    task automatic test_reset_mid;
        int pre[$] = '{8};
        int w[$] = '{9,0,1,0,9,8,7,8,9,0,1,2,1};
        int full[$];
        int e_err, e_cnt;
        logic [CD-1:0] cand;
        reposition(7);
        attempt("rm_pre", pre, 2, 0, code0, 0, 1);
        full = w;
        full.push_front(cur_pos);
        model(full, e_err, e_cnt, cand);
        foreach (w[i]) begin
            set_dial(w[i]);
            hold(2);
        end
        hold(1);
        chk("rm_cnt_before", int'(bus.digits_cnt), e_cnt);
        rst_n = 1'b0;
        hold(1);
        rst_n = 1'b1;
        chk("rm_cnt", int'(bus.digits_cnt), 0);
        chk("rm_fail", int'(bus.fail_cnt), 0);
        chk("rm_open", int'(bus.open), 0);
        chk("rm_locked", int'(bus.locked_out), 0);
        chk("rm_err", int'(bus.entry_err), 0);
        fails_m = 0;
        hold(3);
    endtask

    task automatic test_try_through_reset;
        bus.tryopen = 1'b1;
        rst_n = 1'b0;
        hold(2);
        rst_n = 1'b1;
        hold(6);
        chk("tr_open", int'(bus.open), 0);
        chk("tr_fail", int'(bus.fail_cnt), 0);
        bus.tryopen = 1'b0;
        hold(3);
    endtask

    task automatic test_random;
        int w[$];
        int mode, idx, p, dir, n;
        logic [CD-1:0] cd;
        reposition($urandom_range(0, NP - 1));
        for (int t = 0; t < 30; t++) begin
            for (int k = 0; k < ND; k++)
                cd[(ND-k)*DW-1 -: DW] = DW'($urandom_range(0, NP - 1));
            mode = $urandom_range(0, 4);
            gen(cur_pos, cd, w);
            if (mode == 2) begin
                w.push_back((w[w.size()-1] + 1) % NP);
            end else if (mode == 3) begin
                idx = $urandom_range(0, w.size() - 1);
                w.insert(idx, (w[idx] + $urandom_range(3, 7)) % NP);
            end else if (mode == 4) begin
                w = {};
                p = cur_pos;
                dir = 1;
                n = $urandom_range(3, 20);
                for (int j = 0; j < n; j++) begin
                    if ($urandom_range(0, 9) < 3) dir = -dir;
                    p = (p + dir + NP) % NP;
                    w.push_back(p);
                end
            end
            attempt($sformatf("rnd%0d", t), w, $urandom_range(1, 3),
                    bit'($urandom_range(0, 1)), cd,
                    $urandom_range(0, 2) == 0, 1);
        end
    endtask

    initial begin
        bus.dial = '0;
        bus.tryopen = 1'b0;
        bus.code = '0;
        test_reset();
        test_open();
        test_wrong();
        test_jump();
        test_wrap();
        test_lockout();
        test_reset_mid();
        test_try_through_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
